axi_lite_master: RTL and testbench
==================================

# axi_lite_master

AXI4-Lite master bridge that turns single-beat register commands from the FPU host/sequencer side into AXI4-Lite write or read transactions. It sits directly upstream of `axi_slave_lite` and drives its five channels. It returns the slave's read data and response code through a valid/ready response port. Only one transaction is outstanding at a time, and a response-phase watchdog prevents a silent slave from hanging the host.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI data width.
- `STRB_WIDTH`, DATA_WIDTH/8: write-strobe width.
- `TIMEOUT_CYCLES`, 256: cycles waited for bvalid/rvalid before abort; must be at least 2.
- `aclk` in 1: clock, rising edge.
- `arst` in 1: reset. One clock; reset is asynchronous and active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: full byte address, including the slave base address.
- `cmd_wdata` in DATA_WIDTH / `cmd_wstrb` in STRB_WIDTH: write payload; ignored for reads.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes.
- `rsp_resp` out 2: bresp or rresp; 2'b10 on timeout.
- `rsp_timeout` out 1: response was produced by the watchdog.
- AXI write address channel: `awvalid` out 1, `awaddr` out ADDR_WIDTH, `awready` in 1.
- AXI write data channel: `wvalid` out 1, `wdata` out DATA_WIDTH, `wstrb` out STRB_WIDTH, `wready` in 1.
- AXI write response channel: `bready` out 1, `bresp` in 2, `bvalid` in 1.
- AXI read address channel: `arvalid` out 1, `araddr` out ADDR_WIDTH, `arready` in 1.
- AXI read data channel: `rready` out 1, `rvalid` in 1, `rdata` in DATA_WIDTH, `rresp` in 2.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch cmd_* into registers.
  - Go to WR_REQ if `cmd_write`, else RD_REQ.
- WR_REQ
  - `awvalid` and `wvalid` are both raised on entry.
  - Each one drops independently the cycle after its own handshake (`awvalid&awready`, `wvalid&wready`).
  - Per-channel done flags are kept.
  - Leave for WR_RESP once both flags are set, including a simultaneous handshake.
- WR_RESP
  - `bready` = 1.
  - On `bvalid`, capture `bresp` and go to RSP.
- RD_REQ
  - `arvalid` = 1 until `arready`, then go to RD_RESP.
- RD_RESP
  - `rready` = 1.
  - On `rvalid`, capture `rdata` and `rresp`, then go to RSP.
- RSP
  - `rsp_valid` = 1 and outputs are stable.
  - On `rsp_ready`, return to IDLE.
- AXI address and data outputs come from the latched registers and are stable while valid is high.
- Valid is never dropped before ready. `awaddr`, `araddr`, `wdata` and `wstrb` hold their last value after the handshake.
- Watchdog
  - Counter clears on entry to WR_RESP or RD_RESP and increments each cycle there.
  - At `TIMEOUT_CYCLES`-1 without bvalid/rvalid, go to RSP with `rsp_resp`=2'b10, `rsp_timeout`=1 and `rsp_rdata`=0.
  - Dropping bready/rready is AXI-legal.
- Request phases (WR_REQ, RD_REQ) have no timeout; they wait indefinitely.
- Reset
  - All outputs 0, FSM in IDLE, counter 0. `cmd_ready` is 1 after reset deasserts.
  - A reset mid-transaction abandons it immediately with no response. Any stray beat from the slave after reset is ignored because bready and rready are 0.

## Timing
- All outputs are registered, except `cmd_ready`, which is decoded from the state register.
- Write, zero-wait slave:
  - Cycle 0: command accepted.
  - Cycle 1: `awvalid` and `wvalid` high, both handshakes.
  - Cycle 2: `bready` high, `bvalid` sampled.
  - Cycle 3: `rsp_valid` high.
- Read, zero-wait slave:
  - Cycle 0: command accepted.
  - Cycle 1: `arvalid` high, `arready` handshake.
  - Cycle 2: `rready` high, `rvalid` sampled.
  - Cycle 3: `rsp_valid` high.
- Slave wait states add one cycle each.
- Back-to-back throughput is one transaction per 4 cycles minimum: RSP→IDLE costs one cycle.
- `cmd_ready` is 0 from the acceptance edge until IDLE is re-entered, so a held `cmd_valid` is accepted at most once per transaction.

## Test plan
- Write 0xFFFF_0004, data 0xDEADBEEF, strb 0xF, zero-wait slave → `awaddr`=0xFFFF_0004 and `wdata`=0xDEADBEEF in cycle 1, `rsp_valid` in cycle 3, `rsp_resp`=00, `rsp_timeout`=0.
- Write with `wready` immediate and `awready` delayed 3 cycles → `wvalid` low from cycle 2 while `awvalid` is held to cycle 4; `bready` only in cycle 5; a single response.
- Read 0xFFFF_0008, slave returns rdata 0x3F80_0000 with rresp 00 after 2 wait cycles → `rsp_rdata`=0x3F80_0000, `rsp_resp`=00, `rsp_valid` in cycle 5.
- TIMEOUT_CYCLES=16, bvalid never asserted → `rsp_valid` 16 cycles after WR_RESP entry, `rsp_resp`=10, `rsp_timeout`=1, `bready` low from then on.
- `rsp_ready` held low 5 cycles with `cmd_valid` high → response stable and `cmd_ready`=0 throughout; next command accepted the cycle after the `rsp_ready` handshake.
- `arst` pulsed mid RD_RESP, then a late `rvalid` → all outputs 0 immediately, no `rsp_valid`, `cmd_ready`=1 after release.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite five-channel bundle between a single-beat master and a register slave.
// The master modport drives request channels; the slave modport drives ready/response.
interface axi_lite_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic                  awvalid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awready;
   logic                  wvalid;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wready;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  arvalid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arready;
   logic                  rready;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, input awready,
      output wvalid, wdata, wstrb, input wready,
      output bready, input bresp, bvalid,
      output arvalid, araddr, input arready,
      output rready, input rvalid, rdata, rresp
   );

   modport slave (
      input awvalid, awaddr, output awready,
      input wvalid, wdata, wstrb, output wready,
      input bready, output bresp, bvalid,
      input arvalid, araddr, output arready,
      input rready, output rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: host command in, one AXI read or write out,
// response (or watchdog abort) back through a valid/ready port.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a host command
// WR_REQ  | awvalid/wvalid presented, each dropped after its own handshake
// WR_RESP | bready high, watchdog running
// RD_REQ  | arvalid presented until arready
// RD_RESP | rready high, watchdog running
// RSP     | rsp_valid high, waiting for rsp_ready
module axi_lite_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  aclk,
   input  logic                  arst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   axi_lite_master_if.master     axi
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

   state_t                state;
   logic [CNT_W-1:0]      wd_cnt;
   logic                  aw_done;
   logic                  w_done;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  arvalid_q;
   logic                  bready_q;
   logic                  rready_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  aw_fire;
   logic                  w_fire;

   assign aw_fire = awvalid_q & axi.awready;
   assign w_fire  = wvalid_q & axi.wready;

   // Gated by arst so every output reads 0 while reset is held.
   assign cmd_ready = (state == IDLE) && !arst;

   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = awaddr_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.bready  = bready_q;
   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = araddr_q;
   assign axi.rready  = rready_q;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state       <= IDLE;
         wd_cnt      <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= 2'b00;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_write) begin
                     awaddr_q  <= cmd_addr;
                     wdata_q   <= cmd_wdata;
                     wstrb_q   <= cmd_wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                     state     <= WR_REQ;
                  end else begin
                     araddr_q  <= cmd_addr;
                     arvalid_q <= 1'b1;
                     state     <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (aw_fire) begin
                  awvalid_q <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (w_fire) begin
                  wvalid_q <= 1'b0;
                  w_done   <= 1'b1;
               end
               // Covers one channel finishing earlier as well as both in the same cycle.
               if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                  bready_q <= 1'b1;
                  wd_cnt   <= '0;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axi.bvalid) begin
                  rsp_resp    <= axi.bresp;
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b0;
                  bready_q    <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RSP;
               end else if (wd_cnt == CNT_LAST) begin
                  rsp_resp    <= 2'b10;
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b1;
                  bready_q    <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RSP;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            RD_REQ: begin
               if (axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  wd_cnt    <= '0;
                  state     <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (axi.rvalid) begin
                  rsp_resp    <= axi.rresp;
                  rsp_rdata   <= axi.rdata;
                  rsp_timeout <= 1'b0;
                  rready_q    <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RSP;
               end else if (wd_cnt == CNT_LAST) begin
                  rsp_resp    <= 2'b10;
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b1;
                  rready_q    <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RSP;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: table of directed transactions, a reset-abort sequence,
// then random transactions scored against a cycle-count model of the bridge.
module tb_axi_lite_master;
   localparam int T = 16;
   localparam int NEVER = 1000;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          aw_d;
      int          w_d;
      int          ar_d;
      int          x_d;     // cycles of bready/rready before the slave answers
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          rsp_d;   // cycles rsp_ready held low
      logic        hold;    // keep cmd_valid high through the transaction
      int          exp_cycle;
      logic [1:0]  exp_resp;
      logic        exp_to;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        aclk;
   logic        arst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;

   int n_vec = 0;
   int n_err = 0;

   axi_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) m ();

   axi_lite_master #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(T)
   ) dut (
      .aclk(aclk), .arst(arst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .axi(m)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Expected response from the transaction's shape: request phase ends when the slower
   // channel handshakes, response phase lasts until the beat or the watchdog limit.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int   e;
      r = v;
      e = v.wr ? ((v.aw_d > v.w_d ? v.aw_d : v.w_d) + 2) : (v.ar_d + 2);
      if (v.x_d < T) begin
         r.exp_cycle = e + v.x_d + 1;
         r.exp_resp  = v.resp;
         r.exp_to    = 1'b0;
         r.exp_rdata = v.wr ? 32'h0 : v.rdata;
      end else begin
         r.exp_cycle = e + T;
         r.exp_resp  = 2'b10;
         r.exp_to    = 1'b1;
         r.exp_rdata = 32'h0;
      end
      return r;
   endfunction

   function automatic logic [159:0] all_outputs();
      return 160'({cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                   m.awvalid, m.awaddr, m.wvalid, m.wdata, m.wstrb, m.bready,
                   m.arvalid, m.araddr, m.rready});
   endfunction

   task automatic clear_slave();
      m.awready = 1'b0; m.wready = 1'b0; m.arready = 1'b0;
      m.bvalid = 1'b0; m.bresp = 2'b00;
      m.rvalid = 1'b0; m.rresp = 2'b00; m.rdata = 32'h0;
      rsp_ready = 1'b0;
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      int aw_hi, w_hi, ar_hi, b_hi, r_hi, rsp_cnt, rsp_first, viol, c, exp_x;
      logic [1:0]  g_resp;
      logic        g_to;
      logic [31:0] g_rdata;
      logic        done;
      aw_hi = 0; w_hi = 0; ar_hi = 0; b_hi = 0; r_hi = 0;
      rsp_cnt = 0; rsp_first = -1; viol = 0; c = 0; done = 1'b0;
      g_resp = 2'b00; g_to = 1'b0; g_rdata = 32'h0;
      @(negedge aclk);
      chk($sformatf("v%0d cmd_ready_idle", idx), 160'(cmd_ready), 160'(1));
      cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
      cmd_wdata = v.wdata; cmd_wstrb = v.strb;
      while (!done && c < 300) begin
         @(negedge aclk);
         c++;
         if (!v.hold) cmd_valid = 1'b0;
         if (cmd_ready) viol++;
         if (m.awvalid) begin aw_hi++; if (m.awaddr !== v.addr) viol++; end
         if (m.wvalid) begin
            w_hi++;
            if (m.wdata !== v.wdata || m.wstrb !== v.strb) viol++;
         end
         if (m.arvalid) begin ar_hi++; if (m.araddr !== v.addr) viol++; end
         if (m.bready) b_hi++;
         if (m.rready) r_hi++;
         m.awready = m.awvalid && (aw_hi > v.aw_d);
         m.wready  = m.wvalid && (w_hi > v.w_d);
         m.arready = m.arvalid && (ar_hi > v.ar_d);
         m.bvalid  = m.bready && (b_hi > v.x_d);
         m.rvalid  = m.rready && (r_hi > v.x_d);
         m.bresp   = v.resp;
         m.rresp   = v.resp;
         m.rdata   = m.rvalid ? v.rdata : ~v.rdata;
         if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_first < 0) begin
               rsp_first = c; g_resp = rsp_resp; g_to = rsp_timeout; g_rdata = rsp_rdata;
            end else if ({rsp_resp, rsp_timeout, rsp_rdata} !== {g_resp, g_to, g_rdata}) begin
               viol++;
            end
            rsp_ready = (rsp_cnt > v.rsp_d);
            if (rsp_ready) done = 1'b1;
         end else begin
            rsp_ready = 1'b0;
         end
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL v%0d bound: no response handshake within %0d cycles", idx, c);
      end
      @(posedge aclk);
      #1;
      clear_slave();
      exp_x = (v.x_d < T) ? v.x_d + 1 : T;
      chk($sformatf("v%0d rsp_cycle", idx), 160'(rsp_first), 160'(v.exp_cycle));
      chk($sformatf("v%0d rsp_resp", idx), 160'(g_resp), 160'(v.exp_resp));
      chk($sformatf("v%0d rsp_timeout", idx), 160'(g_to), 160'(v.exp_to));
      chk($sformatf("v%0d rsp_rdata", idx), 160'(g_rdata), 160'(v.exp_rdata));
      chk($sformatf("v%0d rsp_valid_cycles", idx), 160'(rsp_cnt), 160'(v.rsp_d + 1));
      chk($sformatf("v%0d protocol_violations", idx), 160'(viol), 160'(0));
      if (v.wr) begin
         chk($sformatf("v%0d awvalid_cycles", idx), 160'(aw_hi), 160'(v.aw_d + 1));
         chk($sformatf("v%0d wvalid_cycles", idx), 160'(w_hi), 160'(v.w_d + 1));
         chk($sformatf("v%0d bready_cycles", idx), 160'(b_hi), 160'(exp_x));
         chk($sformatf("v%0d read_chan_idle", idx), 160'(ar_hi + r_hi), 160'(0));
      end else begin
         chk($sformatf("v%0d arvalid_cycles", idx), 160'(ar_hi), 160'(v.ar_d + 1));
         chk($sformatf("v%0d rready_cycles", idx), 160'(r_hi), 160'(exp_x));
         chk($sformatf("v%0d write_chan_idle", idx), 160'(aw_hi + w_hi + b_hi), 160'(0));
      end
   endtask

   vec_t tbl[9];
   vec_t rv;

   initial begin
      // wr addr wdata strb aw w ar x resp rdata rsp_d hold | cycle resp to rdata
      tbl[0] = '{1'b1, 32'hFFFF_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0,
                 3, 2'b00, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 32'hFFFF_000C, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0,
                 6, 2'b00, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 32'hFFFF_0008, 32'h0, 4'h0, 0, 0, 0, 2, 2'b00, 32'h3F80_0000, 0, 1'b0,
                 5, 2'b00, 1'b0, 32'h3F80_0000};
      tbl[3] = '{1'b1, 32'hFFFF_0010, 32'hCAFE_0001, 4'hF, 0, 0, 0, NEVER, 2'b00, 32'h0, 0, 1'b0,
                 18, 2'b10, 1'b1, 32'h0};
      tbl[4] = '{1'b0, 32'hFFFF_0014, 32'h0, 4'h0, 0, 0, 0, 0, 2'b01, 32'h1234_5678, 5, 1'b1,
                 3, 2'b01, 1'b0, 32'h1234_5678};
      tbl[5] = '{1'b0, 32'hFFFF_0018, 32'h0, 4'h0, 0, 0, 1, T - 1, 2'b11, 32'hA5A5_5A5A, 0, 1'b0,
                 19, 2'b11, 1'b0, 32'hA5A5_5A5A};
      tbl[6] = '{1'b0, 32'hFFFF_001C, 32'h0, 4'h0, 0, 0, 0, NEVER, 2'b00, 32'h7777_7777, 1, 1'b0,
                 18, 2'b10, 1'b1, 32'h0};
      tbl[7] = '{1'b1, 32'hFFFF_0020, 32'h0BAD_F00D, 4'h5, 0, 2, 0, 1, 2'b11, 32'h0, 0, 1'b0,
                 6, 2'b11, 1'b0, 32'h0};
      tbl[8] = '{1'b1, 32'hFFFF_0024, 32'h5555_AAAA, 4'hC, 1, 1, 0, T, 2'b01, 32'h0, 0, 1'b0,
                 19, 2'b10, 1'b1, 32'h0};

      arst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      clear_slave();
      #7;
      chk("reset outputs zero", all_outputs(), 160'(0));
      @(negedge aclk);
      arst = 1'b0;
      #1;
      chk("reset cmd_ready after release", 160'(cmd_ready), 160'(1));

      for (int i = 0; i < 9; i++) run_txn(tbl[i], i);
      cmd_valid = 1'b0;

      // Reset while waiting in the read response phase, then a stray rvalid.
      @(negedge aclk);
      chk("abort cmd_ready", 160'(cmd_ready), 160'(1));
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hFFFF_0030; m.arready = 1'b1;
      @(negedge aclk);
      cmd_valid = 1'b0;
      chk("abort arvalid", 160'(m.arvalid), 160'(1));
      @(negedge aclk);
      chk("abort rready", 160'(m.rready), 160'(1));
      m.arready = 1'b0;
      #1 arst = 1'b1;
      #1;
      chk("abort outputs zero", all_outputs(), 160'(0));
      @(negedge aclk);
      arst = 1'b0;
      m.rvalid = 1'b1; m.rdata = 32'hFEED_FACE; m.rresp = 2'b01;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         chk($sformatf("abort stray rvalid c%0d", i),
             160'({rsp_valid, m.rready, m.arvalid, cmd_ready}), 160'(4'b0001));
      end
      clear_slave();

      for (int i = 0; i < 40; i++) begin
         rv.wr    = 1'($urandom_range(0, 1));
         rv.addr  = $urandom;
         rv.wdata = $urandom;
         rv.strb  = 4'($urandom_range(0, 15));
         rv.aw_d  = $urandom_range(0, 3);
         rv.w_d   = $urandom_range(0, 3);
         rv.ar_d  = $urandom_range(0, 3);
         case ($urandom_range(0, 9))
            7:       rv.x_d = T - 1;
            8:       rv.x_d = T;
            9:       rv.x_d = NEVER;
            default: rv.x_d = $urandom_range(0, 3);
         endcase
         rv.resp  = 2'($urandom_range(0, 3));
         rv.rdata = $urandom;
         rv.rsp_d = $urandom_range(0, 3);
         rv.hold  = 1'($urandom_range(0, 1));
         rv = model(rv);
         run_txn(rv, 100 + i);
      end
      cmd_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
